// File: rtl/ripple_carry_adder_pkg.sv
// Shared constants for the ripple-carry adder and the blocks that instantiate it.
package ripple_carry_adder_pkg;

    localparam int unsigned ADDER_WIDTH = 4;

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// 1-bit full adder cell; the ripple-carry adder chains WIDTH of these.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder: combinational sum/cout plus a one-cycle
// registered copy (with signed overflow) qualified by out_valid.
module ripple_carry_adder
    import ripple_carry_adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             ovf_q,
    output logic             out_valid
);

    logic [WIDTH:0] c;
    logic           ovf;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[WIDTH];
    // Carry into and out of the sign bit disagree exactly on signed overflow.
    assign ovf  = c[WIDTH] ^ c[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q  <= sum;
                cout_q <= cout;
                ovf_q  <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Directed and exhaustive self-checking bench for ripple_carry_adder at the default width.
module tb_ripple_carry_adder;
    import ripple_carry_adder_pkg::*;

    localparam int unsigned W = ADDER_WIDTH;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         in_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic [W-1:0] sum_q;
    logic         cout_q;
    logic         ovf_q;
    logic         out_valid;

    int total;
    int bad;

    ripple_carry_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .sum       (sum),
        .cout      (cout),
        .sum_q     (sum_q),
        .cout_q    (cout_q),
        .ovf_q     (ovf_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Comb check 10 ns after apply (one full period from the negedge), register check just after the edge in between.
    task automatic vec(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                       input logic [3:0] es, input logic ec, input logic eo, input string tag);
        @(negedge clk);
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " sum_q"},  32'(sum_q),  32'(es));
        check({tag, " cout_q"}, 32'(cout_q), 32'(ec));
        check({tag, " ovf_q"},  32'(ovf_q),  32'(eo));
        check({tag, " valid"},  32'(out_valid), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, " sum"},  32'(sum),  32'(es));
        check({tag, " cout"}, 32'(cout), 32'(ec));
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        a = '0; b = '0; cin = 1'b0; in_valid = 1'b0;
        #2;
        check("rst sum_q",  32'(sum_q),  32'd0);
        check("rst cout_q", 32'(cout_q), 32'd0);
        check("rst ovf_q",  32'(ovf_q),  32'd0);
        check("rst valid",  32'(out_valid), 32'd0);
        check("zero sum",   32'(sum),  32'd0);
        check("zero cout",  32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        vec(4'b0001, 4'b0101, 1'b0, 4'b0110, 1'b0, 1'b0, "v1");
        vec(4'b1110, 4'b1001, 1'b1, 4'b1000, 1'b1, 1'b0, "v2");
        vec(4'b0111, 4'b1101, 1'b0, 4'b0100, 1'b1, 1'b0, "v3");
        vec(4'b1001, 4'b0101, 1'b1, 4'b1111, 1'b0, 1'b0, "v4");
        vec(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, "ones");
        vec(4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1, "negovf");
        vec(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, "posovf");

        // in_valid already dropped by vec; next edge clears out_valid and holds data
        @(posedge clk);
        #1;
        check("hold valid",  32'(out_valid), 32'd0);
        check("hold sum_q",  32'(sum_q),  32'b1000);
        check("hold ovf_q",  32'(ovf_q),  32'd1);

        vec(4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b0, "prerst");
        #2;
        rst = 1'b1;
        #1;
        check("async sum_q",  32'(sum_q),  32'd0);
        check("async cout_q", 32'(cout_q), 32'd0);
        check("async ovf_q",  32'(ovf_q),  32'd0);
        check("async valid",  32'(out_valid), 32'd0);
        check("rst comb sum", 32'(sum), 32'b0111);

        // In-flight sample under reset must be discarded
        a = 4'b0111; b = 4'b0001; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("inflight valid", 32'(out_valid), 32'd0);
        check("inflight sum_q", 32'(sum_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;

        for (int i = 0; i < 512; i++) begin
            logic [8:0] iv;
            logic [4:0] exp5;
            logic       eo;
            iv = 9'(i);
            @(negedge clk);
            a = iv[3:0]; b = iv[7:4]; cin = iv[8]; in_valid = 1'b1;
            exp5 = 5'(iv[3:0]) + 5'(iv[7:4]) + 5'(iv[8]);
            eo = (iv[3] == iv[7]) && (exp5[3] != iv[3]);
            #1;
            check($sformatf("sweep %0d sum", i), 32'({cout, sum}), 32'(exp5));
            @(posedge clk);
            #1;
            check($sformatf("sweep %0d reg", i), 32'({ovf_q, cout_q, sum_q, out_valid}),
                  32'({eo, exp5, 1'b1}));
        end
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
